// File: rtl/nibble_adder_pkg.sv
// Shared definitions for the nibble-serial adder controller and its 4-bit slice.
package nibble_adder_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   function automatic bit width_is_valid(input int width);
      return (width >= NIBBLE_W) && ((width % NIBBLE_W) == 0);
   endfunction

endpackage

// File: rtl/brent_kung_adder_4bit.sv
// Combinational 4-bit Brent-Kung adder slice; the port set is shared with the
// approximate slices that may later replace it.
module brent_kung_adder_4bit (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       cin,
   output logic [3:0] sum,
   output logic       carry_out
);

   logic [3:0] g_s;
   logic [3:0] p_s;
   logic [3:0] c_s;
   logic       g0c_s;
   logic       g10_s;
   logic       g32_s;
   logic       p32_s;

   assign g_s = a & b;
   assign p_s = a ^ b;

   // Carry-in is folded into the bit-0 generate so the tree needs no extra level.
   assign g0c_s = g_s[0] | (p_s[0] & cin);
   assign g10_s = g_s[1] | (p_s[1] & g0c_s);
   assign g32_s = g_s[3] | (p_s[3] & g_s[2]);
   assign p32_s = p_s[3] & p_s[2];

   assign c_s       = {g_s[2] | (p_s[2] & g10_s), g10_s, g0c_s, cin};
   assign sum       = p_s ^ c_s;
   assign carry_out = g32_s | (p32_s & g10_s);

endmodule

// File: rtl/nibble_serial_adder_ctrl.sv
// WIDTH-bit adder built from one 4-bit slice, one nibble per clock, LSB nibble
// first, with valid/ready handshakes on operand and result sides.
module nibble_serial_adder_ctrl
   import nibble_adder_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             busy
);

   localparam int NIB   = WIDTH / NIBBLE_W;
   localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NIB - 1);

   if (!width_is_valid(WIDTH)) begin : g_bad_width
      $error("nibble_serial_adder_ctrl: WIDTH must be a positive multiple of 4");
   end

   state_t              state_r;
   state_t              state_next_s;
   logic [CNT_W-1:0]    cnt_r;
   logic [WIDTH-1:0]    a_sh_r;
   logic [WIDTH-1:0]    b_sh_r;
   logic [WIDTH-1:0]    sum_r;
   logic                carry_r;
   logic                in_ready_r;
   logic                accept_s;
   logic                last_s;
   logic [NIBBLE_W-1:0] slice_sum_s;
   logic                slice_cout_s;

   assign accept_s = in_valid & in_ready_r & (state_r == IDLE);
   assign last_s   = (cnt_r == LAST_CNT);

   brent_kung_adder_4bit u_slice (
      .a         (a_sh_r[NIBBLE_W-1:0]),
      .b         (b_sh_r[NIBBLE_W-1:0]),
      .cin       (carry_r),
      .sum       (slice_sum_s),
      .carry_out (slice_cout_s)
   );

   // Next-state decode for the IDLE/RUN/DONE sequencer.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         IDLE: begin
            if (accept_s) state_next_s = RUN;
            else          state_next_s = IDLE;
         end
         RUN: begin
            if (last_s) state_next_s = DONE;
            else        state_next_s = RUN;
         end
         DONE: begin
            if (out_ready) state_next_s = IDLE;
            else           state_next_s = DONE;
         end
         default: state_next_s = IDLE;
      endcase
   end

   // State register; in_ready is registered so it is low throughout reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r    <= IDLE;
         in_ready_r <= 1'b0;
      end else begin
         state_r    <= state_next_s;
         in_ready_r <= (state_next_s == IDLE);
      end
   end

   // Operand shifters, result shifter, inter-nibble carry and step counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh_r  <= {WIDTH{1'b0}};
         b_sh_r  <= {WIDTH{1'b0}};
         sum_r   <= {WIDTH{1'b0}};
         carry_r <= 1'b0;
         cnt_r   <= {CNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (accept_s) begin
                  a_sh_r  <= a;
                  b_sh_r  <= b;
                  carry_r <= cin;
                  cnt_r   <= {CNT_W{1'b0}};
               end
            end
            RUN: begin
               a_sh_r  <= a_sh_r >> NIBBLE_W;
               b_sh_r  <= b_sh_r >> NIBBLE_W;
               // New nibble enters at the top so nibble 0 ends at bit 0 after NIB steps.
               sum_r   <= (sum_r >> NIBBLE_W) | (WIDTH'(slice_sum_s) << (WIDTH - NIBBLE_W));
               carry_r <= slice_cout_s;
               if (!last_s) cnt_r <= cnt_r + CNT_W'(1);
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = (state_r == DONE);
   assign busy      = (state_r != IDLE);
   assign sum       = sum_r;
   assign cout      = carry_r;

endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// Scoreboard bench: directed and random operations on a 16-bit instance, plus
// random-only harnesses on 4-bit and 32-bit instances.
module tb_nibble_serial_adder_ctrl;

   localparam int WIDTH = 16;

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             busy;

   int               total = 0;
   int               bad   = 0;
   int               mode  = 0;
   time              t_acc;
   logic [WIDTH:0]   exp_q[$];
   logic [WIDTH:0]   exp_m;

   always #5 clk = ~clk;

   nibble_serial_adder_ctrl #(.WIDTH(WIDTH)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .busy      (busy)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   function automatic logic [WIDTH:0] golden(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                             input logic c);
      return {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [WIDTH-1:0] xa, input logic [WIDTH-1:0] xb, input logic xc);
      int n;
      n = 0;
      a = xa; b = xb; cin = xc; in_valid = 1'b1;
      while (!in_ready && n < 200) begin
         tick();
         n++;
      end
      chk("accept", 64'(in_ready), 64'd1);
      exp_q.push_back(golden(xa, xb, xc));
      tick();
      t_acc = $time;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         tick();
         n++;
      end
      chk("drain", 64'(exp_q.size()), 64'd0);
   endtask

   // Consumer: 0 = always ready, 1 = stalled, 2 = random.
   initial begin
      out_ready = 1'b1;
      forever begin
         @(posedge clk);
         #2;
         out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? 1'b0 : 1'($urandom);
      end
   end

   // Monitor: every result handshake pops and checks one expectation.
   always @(negedge clk) begin
      if (!rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_result: got %0h expected no result", sum);
         end else begin
            exp_m = exp_q.pop_front();
            chk("sum", 64'(sum), 64'(exp_m[WIDTH-1:0]));
            chk("cout", 64'(cout), 64'(exp_m[WIDTH]));
         end
      end
   end

   initial begin
      int  n;
      time t1;
      logic [WIDTH:0] bp_exp;
      rst = 1'b1; in_valid = 1'b0; a = 16'h0000; b = 16'h0000; cin = 1'b0;
      repeat (3) tick();
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_cout", 64'(cout), 64'd0);
      rst = 1'b0;
      tick();
      chk("post_rst_in_ready", 64'(in_ready), 64'd1);

      send(16'h1234, 16'h1111, 1'b0);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      chk("latency", 64'(n), 64'd4);
      send(16'hFFFF, 16'h0001, 1'b0);
      send(16'h0000, 16'hFFFF, 1'b1);
      send(16'h8000, 16'h8000, 1'b0);
      t1 = t_acc;
      send(16'h7FFF, 16'h0001, 1'b1);
      chk("issue_interval", 64'((t_acc - t1) / 10), 64'd6);
      drain();

      // Backpressure: result must hold while the inputs churn.
      mode = 1;
      bp_exp = golden(16'hABCD, 16'h1357, 1'b1);
      send(16'hABCD, 16'h1357, 1'b1);
      n = 0;
      while (!out_valid && n < 50) begin
         tick();
         n++;
      end
      for (int i = 0; i < 5; i++) begin
         in_valid = ~in_valid;
         a = 16'($urandom);
         b = 16'($urandom);
         cin = 1'($urandom);
         tick();
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_sum", 64'(sum), 64'(bp_exp[WIDTH-1:0]));
         chk("bp_cout", 64'(cout), 64'(bp_exp[WIDTH]));
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_busy", 64'(busy), 64'd1);
      end
      in_valid = 1'b0;
      mode = 0;
      send(16'h0F0F, 16'hF0F1, 1'b0);
      drain();

      // Reset during the second RUN cycle aborts the operation.
      send(16'h5555, 16'hAAAA, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      chk("abort_out_valid", 64'(out_valid), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_sum", 64'(sum), 64'd0);
      chk("abort_cout", 64'(cout), 64'd0);
      rst = 1'b0;
      exp_q.delete();
      tick();
      chk("abort_in_ready", 64'(in_ready), 64'd1);
      chk("abort_idle_out_valid", 64'(out_valid), 64'd0);
      send(16'h00FF, 16'h0001, 1'b0);
      drain();

      mode = 2;
      for (int k = 0; k < 1000; k++) begin
         repeat ($urandom_range(0, 3)) tick();
         send(16'($urandom), 16'($urandom), 1'($urandom));
      end
      drain();
      mode = 0;

      n = 0;
      while (!(g_w[0].r_done && g_w[1].r_done) && n < 40000) begin
         tick();
         n++;
      end
      chk("aux_done", 64'(g_w[0].r_done && g_w[1].r_done), 64'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Random-only harnesses for the narrowest and a wider configuration.
   for (genvar gi = 0; gi < 2; gi++) begin : g_w
      localparam int W = (gi == 0) ? 4 : 32;

      logic         r_rst;
      logic         r_iv;
      logic         r_ir;
      logic         r_cin;
      logic         r_ov;
      logic         r_or;
      logic         r_cout;
      logic         r_busy;
      logic [W-1:0] r_a;
      logic [W-1:0] r_b;
      logic [W-1:0] r_sum;
      logic [W:0]   r_q[$];
      logic [W:0]   r_e;
      bit           r_done = 1'b0;

      nibble_serial_adder_ctrl #(.WIDTH(W)) u_dut (
         .clk       (clk),
         .rst       (r_rst),
         .in_valid  (r_iv),
         .in_ready  (r_ir),
         .a         (r_a),
         .b         (r_b),
         .cin       (r_cin),
         .out_valid (r_ov),
         .out_ready (r_or),
         .sum       (r_sum),
         .cout      (r_cout),
         .busy      (r_busy)
      );

      initial begin
         r_or = 1'b0;
         forever begin
            @(posedge clk);
            #2;
            r_or = 1'($urandom);
         end
      end

      always @(negedge clk) begin
         if (!r_rst && r_ov && r_or) begin
            if (r_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL w%0d_unexpected_result: got %0h expected no result", W, r_sum);
            end else begin
               r_e = r_q.pop_front();
               chk($sformatf("w%0d_sum", W), 64'(r_sum), 64'(r_e[W-1:0]));
               chk($sformatf("w%0d_cout", W), 64'(r_cout), 64'(r_e[W]));
               chk($sformatf("w%0d_busy", W), 64'(r_busy), 64'd1);
            end
         end
      end

      initial begin
         int n;
         r_rst = 1'b1; r_iv = 1'b0; r_cin = 1'b0;
         r_a = W'(0); r_b = W'(0);
         repeat (3) begin @(posedge clk); #1; end
         r_rst = 1'b0;
         for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            r_a = W'($urandom); r_b = W'($urandom); r_cin = 1'($urandom); r_iv = 1'b1;
            n = 0;
            while (!r_ir && n < 200) begin
               @(posedge clk); #1;
               n++;
            end
            chk($sformatf("w%0d_accept", W), 64'(r_ir), 64'd1);
            r_q.push_back({1'b0, r_a} + {1'b0, r_b} + (W+1)'(r_cin));
            @(posedge clk); #1;
            r_iv = 1'b0;
         end
         n = 0;
         while (r_q.size() != 0 && n < 500) begin
            @(posedge clk); #1;
            n++;
         end
         chk($sformatf("w%0d_drain", W), 64'(r_q.size()), 64'd0);
         r_done = 1'b1;
      end
   end

endmodule
